// File: rtl/ssb_drv_pkg.sv
// Shared types and constants for the SSB H-bridge drive generator.
package ssb_drv_pkg;

    // Top-level sequencing of the bridge drive.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } ssb_state_t;

    // Bridge patterns, packed as {DRV0, DRV1}.
    localparam logic [1:0] DRV_OFF = 2'b00;
    localparam logic [1:0] DRV_P   = 2'b01;
    localparam logic [1:0] DRV_N   = 2'b10;
    localparam logic [1:0] DRV_Z   = 2'b11;

    // Accumulator width derived from the base phase resolution.
    function automatic int acc_width(input int nbits);
        return nbits + 3;
    endfunction

endpackage

// File: rtl/ssb_deadtime_gate.sv
// Dead-time gate: forces Z between opposite polarities until enough Z cycles
// have been driven. Remembers the last non-Z polarity and counts consecutive Z.
module ssb_deadtime_gate
    import ssb_drv_pkg::*;
#(
    parameter int DT_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [1:0]         raw,
    input  logic [DT_BITS-1:0] dead_time,
    output logic [1:0]         gated
);

    logic [1:0]         last_pol;
    logic [DT_BITS-1:0] z_cnt;
    logic               reversal;

    // A reversal is allowed only once z_cnt has reached dead_time; dead_time=0 never blocks.
    always_comb begin
        reversal = ((raw == DRV_P) && (last_pol == DRV_N)) ||
                   ((raw == DRV_N) && (last_pol == DRV_P));
        gated    = raw;
        if (reversal && (z_cnt < dead_time)) begin
            gated = DRV_Z;
        end
    end

    // Polarity memory and saturating count of consecutive Z outputs.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            last_pol <= DRV_OFF;
            z_cnt    <= '0;
        end else if (gated == DRV_Z) begin
            if (z_cnt != {DT_BITS{1'b1}}) begin
                z_cnt <= z_cnt + DT_BITS'(1);
            end
        end else begin
            z_cnt    <= '0;
            last_pol <= gated;
        end
    end

endmodule

// File: rtl/ssb_bridge_driver.sv
// SSB H-bridge drive generator: phase accumulator folded into a triangle,
// compared against a ramped amplitude to give a three-level bridge drive,
// with shadowed settings applied at phase wrap and dead-time insertion.
module ssb_bridge_driver
    import ssb_drv_pkg::*;
#(
    parameter int NBITS     = 24,
    parameter int DT_BITS   = 4,
    parameter int RAMP_BITS = 16,
    parameter int RAMP_DIV  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NBITS-11:0]    delta_phase,
    input  logic [NBITS-7:0]     ssb_freq,
    input  logic [NBITS+2:0]     amplitude,
    input  logic [RAMP_BITS-1:0] ramp_step,
    input  logic [DT_BITS-1:0]   dead_time,
    input  logic                 stdby,
    output logic                 DRV0,
    output logic                 DRV1,
    output logic                 running,
    output logic                 ramping
);

    localparam int           W          = acc_width(NBITS);
    localparam int           FW         = NBITS - 6;
    localparam int           DW         = NBITS - 10;
    localparam int           PW         = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [W-1:0]  HALF       = {1'b1, {(W-1){1'b0}}};

    ssb_state_t     state, state_nxt;
    logic [W-1:0]   acc;
    logic [FW-1:0]  freq_sh, freq_nxt;
    logic [DW-1:0]  dphase_sh, dphase_nxt;
    logic [W-1:0]   amp_tgt, tgt_nxt;
    logic [W-1:0]   amp_cur, amp_nxt;
    logic [PW-1:0]  presc;
    logic [1:0]     drv_q, drv_nxt;
    logic           running_nxt, ramping_nxt;

    logic [W-1:0]   inc;
    logic [W:0]     acc_sum;
    logic           wrap;
    logic           load_sh;
    logic [W-1:0]   amp_clamped;
    logic           in_ramp;
    logic           tick;
    logic           step_now;
    logic [W-1:0]   step_w;
    logic [W:0]     up_sum;
    logic [W-1:0]   amp_up;
    logic [W-1:0]   amp_floor;
    logic [W:0]     dn_lim;
    logic [W-1:0]   amp_dn;
    logic           resume_up;
    logic [W-1:0]   count;
    logic [W:0]     half_minus;
    logic [1:0]     raw_drv;
    logic [1:0]     gated_drv;

    // Increment, wrap detection, shadow load values and ramp arithmetic.
    always_comb begin
        inc         = {{(W-FW){1'b0}}, freq_sh} + {{(W-DW){1'b0}}, dphase_sh};
        acc_sum     = {1'b0, acc} + {1'b0, inc};
        wrap        = acc_sum[W];
        load_sh     = (state == IDLE) || wrap;
        amp_clamped = (amplitude > HALF) ? HALF : amplitude;
        tgt_nxt     = load_sh ? amp_clamped : amp_tgt;
        freq_nxt    = load_sh ? ssb_freq : freq_sh;
        dphase_nxt  = load_sh ? delta_phase : dphase_sh;

        in_ramp     = (state == RAMP_UP) || (state == RAMP_DOWN);
        tick        = in_ramp && (presc == PRESC_LAST);
        step_now    = tick || (ramp_step == '0);
        step_w      = {{(W-RAMP_BITS){1'b0}}, ramp_step};

        // Up: min(amp_cur + step, target), computed wide so it cannot overshoot.
        up_sum      = {1'b0, amp_cur} + {1'b0, step_w};
        amp_up      = ((ramp_step == '0) || (up_sum >= {1'b0, tgt_nxt})) ? tgt_nxt : up_sum[W-1:0];

        // Down: max(amp_cur - step, floor); floor is zero when heading to standby.
        amp_floor   = stdby ? '0 : tgt_nxt;
        dn_lim      = {1'b0, amp_floor} + {1'b0, step_w};
        amp_dn      = ((ramp_step == '0) || ({1'b0, amp_cur} < dn_lim)) ? amp_floor : (amp_cur - step_w);
        resume_up   = !stdby && (amp_cur < tgt_nxt);
    end

    // Amplitude update for the current state.
    always_comb begin
        amp_nxt = amp_cur;
        case (state)
            IDLE:      amp_nxt = '0;
            RAMP_UP:   if (!stdby && step_now) amp_nxt = amp_up;
            RUN:       amp_nxt = amp_cur;
            RAMP_DOWN: if (!resume_up && step_now) amp_nxt = amp_dn;
            default:   amp_nxt = '0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!stdby) state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                if (stdby)                      state_nxt = RAMP_DOWN;
                else if (amp_nxt == tgt_nxt)    state_nxt = RUN;
            end
            RUN: begin
                if (stdby)                      state_nxt = RAMP_DOWN;
                else if (tgt_nxt > amp_cur)     state_nxt = RAMP_UP;
                else if (tgt_nxt < amp_cur)     state_nxt = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (resume_up)                          state_nxt = RAMP_UP;
                else if (stdby && (amp_nxt == '0))      state_nxt = IDLE;
                else if (!stdby && (amp_nxt == tgt_nxt)) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Folded triangle and raw P/N/Z decision; 2^(W-1)-amp_cur needs W+1 bits.
    always_comb begin
        count      = acc[W-1] ? ~acc : acc;
        half_minus = {1'b0, HALF} - {1'b0, amp_cur};
        if (count < amp_cur)                  raw_drv = DRV_P;
        else if ({1'b0, count} > half_minus)  raw_drv = DRV_N;
        else                                  raw_drv = DRV_Z;
    end

    ssb_deadtime_gate #(
        .DT_BITS (DT_BITS)
    ) u_gate (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == IDLE),
        .raw       (raw_drv),
        .dead_time (dead_time),
        .gated     (gated_drv)
    );

    // Output decode: bridge OFF whenever idle or entering idle.
    always_comb begin
        drv_nxt     = ((state == IDLE) || (state_nxt == IDLE)) ? DRV_OFF : gated_drv;
        running_nxt = (state_nxt == RUN);
        ramping_nxt = (state_nxt == RAMP_UP) || (state_nxt == RAMP_DOWN);
    end

    // State register with status outputs registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
            ramping <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= running_nxt;
            ramping <= ramping_nxt;
        end
    end

    // Datapath registers: accumulator, shadows, amplitude, prescaler, drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            freq_sh   <= '0;
            dphase_sh <= '0;
            amp_tgt   <= '0;
            amp_cur   <= '0;
            presc     <= '0;
            drv_q     <= DRV_OFF;
        end else begin
            acc       <= ((state == IDLE) || (state_nxt == IDLE)) ? '0 : acc_sum[W-1:0];
            freq_sh   <= freq_nxt;
            dphase_sh <= dphase_nxt;
            amp_tgt   <= tgt_nxt;
            amp_cur   <= amp_nxt;
            presc     <= in_ramp ? (tick ? '0 : presc + PW'(1)) : '0;
            drv_q     <= drv_nxt;
        end
    end

    assign DRV0 = drv_q[1];
    assign DRV1 = drv_q[0];

endmodule
